// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned BLOCK_BITS      = 512;
  localparam int unsigned BLOCK_BYTES     = BLOCK_BITS / 8;
  localparam int unsigned WORD_BITS       = 32;
  localparam int unsigned WCNT_W          = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned POS_W           = $clog2(BLOCK_BYTES) + 1;
  localparam int unsigned LEN_W           = 64;
  localparam int unsigned LEN_BYTE_OFS    = 56;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } state_e;

endpackage

// File: rtl/sha256_pad_mask.sv
// Maps the end-of-message byte position to a byte keep mask and the 0x80 pad location.
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  logic [POS_W-1:0]       pos_i,
  output logic [BLOCK_BYTES-1:0] keep_o,
  output logic                   pad_en_o,
  output logic [POS_W-2:0]       pad_pos_o
);

  // Byte i carries message data only when it lies before the end position.
  always_comb begin
    keep_o = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      keep_o[i] = (POS_W'(i) < pos_i);
    end
  end

  assign pad_en_o  = (pos_i < POS_W'(BLOCK_BYTES));
  assign pad_pos_o = pos_i[POS_W-2:0];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into padded 512-bit blocks.
// Optional SHA256_PADDER_BLKCNT_EN adds a blk_count port counting block transfers.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_BITS-1:0]  in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_bytes,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [BLOCK_BITS-1:0] blk_data,
  output logic                  blk_last
`ifdef SHA256_PADDER_BLKCNT_EN
  ,
  output logic [31:0]           blk_count
`endif
);

  state_e                  state_q, state_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [BLOCK_BITS-1:0]   blk_q, blk_d;
  logic                    last_q, last_d;
  logic                    extra_q, extra_d;
  logic                    pad64_q, pad64_d;

  logic [2:0]              nbytes;
  logic [POS_W-1:0]        pos;
  logic [LEN_W-1:0]        len_add;
  logic [BLOCK_BITS-1:0]   blk_wr;
  logic [BLOCK_BYTES-1:0]  keep;
  logic                    pad_en;
  logic [POS_W-2:0]        pad_pos;

  assign nbytes  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign pos     = POS_W'({wcnt_q, 2'b00}) + POS_W'(nbytes);
  assign len_add = in_last ? (LEN_W'(nbytes) << 3) : LEN_W'(WORD_BITS);

  sha256_pad_mask u_pad_mask (
    .pos_i     (pos),
    .keep_o    (keep),
    .pad_en_o  (pad_en),
    .pad_pos_o (pad_pos)
  );

  // Current block with the incoming word written at slot wcnt.
  always_comb begin
    blk_wr = blk_q;
    for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
      if (WCNT_W'(w) == wcnt_q) blk_wr[BLOCK_BITS-1-WORD_BITS*w -: WORD_BITS] = in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    len_d   = len_q;
    blk_d   = blk_q;
    last_d  = last_q;
    extra_d = extra_q;
    pad64_d = pad64_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          len_d  = len_q + len_add;
          blk_d  = blk_wr;
          if (in_last) begin
            for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
              if (!keep[i]) begin
                blk_d[BLOCK_BITS-1-8*i -: 8] =
                  (pad_en && (pad_pos == (POS_W-1)'(i))) ? PAD_BYTE : 8'h00;
              end
            end
            // Length fits behind the pad byte only when the message ends before byte 56.
            if (pos < POS_W'(LEN_BYTE_OFS)) begin
              blk_d[LEN_W-1:0] = len_d;
              last_d           = 1'b1;
              extra_d          = 1'b0;
            end else begin
              last_d  = 1'b0;
              extra_d = 1'b1;
            end
            pad64_d = !pad_en;
            state_d = EMIT;
          end else if (wcnt_q == WCNT_W'(WORDS_PER_BLOCK - 1)) begin
            last_d  = 1'b0;
            extra_d = 1'b0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (last_q) begin
            wcnt_d  = '0;
            len_d   = '0;
            last_d  = 1'b0;
            state_d = FILL;
          end else if (extra_q) begin
            blk_d            = '0;
            blk_d[LEN_W-1:0] = len_q;
            if (pad64_q) blk_d[BLOCK_BITS-1 -: 8] = PAD_BYTE;
            last_d  = 1'b1;
            extra_d = 1'b0;
            state_d = EXTRA;
          end else begin
            state_d = FILL;
          end
        end
      end
      EXTRA: begin
        if (blk_ready) begin
          wcnt_d  = '0;
          len_d   = '0;
          last_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      pad64_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      pad64_q <= pad64_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT) || (state_q == EXTRA);
  assign blk_data  = blk_q;
  assign blk_last  = last_q;

`ifdef SHA256_PADDER_BLKCNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (blk_valid && blk_ready) cnt_q <= cnt_q + 32'd1;
  end

  assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed vector table, stall/reset sequences and random messages
// checked against a byte-level SHA-256 padding model.
module tb_sha256_padder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
`ifdef SHA256_PADDER_BLKCNT_EN
  logic [31:0]  blk_count;
`endif

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
`ifdef SHA256_PADDER_BLKCNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tot_blk = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];

  typedef struct {
    int          nbytes;
    logic [7:0]  base;
    bit          split;
    int          nblk;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Standard SHA-256 padding of msg_q, split into 512-bit blocks.
  task automatic build_model();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] b;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    exp_q.delete();
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[64*bi+i];
      exp_q.push_back(b);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    tot_blk = 0;
  endtask

  // Sends msg_q as words and checks every emitted block against the model.
  task automatic run_msg(input bit split_empty, input bit rnd,
                         output int nblk, output logic [511:0] lastb);
    logic [31:0] wd[$];
    bit          wl[$];
    logic [2:0]  wb[$];
    logic [31:0] w;
    int          len;
    int          wi;
    int          cyc;
    bit          done;
    build_model();
    len   = msg_q.size();
    wi    = 0;
    cyc   = 0;
    done  = 1'b0;
    nblk  = 0;
    lastb = '0;
    for (int k = 0; k < len; k += 4) begin
      int nb;
      nb = (len - k >= 4) ? 4 : len - k;
      w  = $urandom;
      for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg_q[k+j];
      wd.push_back(w);
      wb.push_back(3'(nb));
      wl.push_back(1'b0);
    end
    if (len == 0 || (split_empty && (len % 4) == 0)) begin
      wd.push_back($urandom);
      wb.push_back(3'd0);
      wl.push_back(1'b1);
    end else begin
      wl[wl.size()-1] = 1'b1;
    end
    while (!done && cyc < 4000) begin
      @(negedge clk);
      in_valid  = (wi < wd.size()) && (!rnd || ($urandom_range(3) != 0));
      if (wi < wd.size()) begin
        in_data  = wd[wi];
        in_last  = wl[wi];
        in_bytes = wb[wi];
      end
      blk_ready = !rnd || ($urandom_range(1) == 1);
      if (in_valid && in_ready) wi++;
      if (blk_valid && blk_ready) begin
        if (nblk < exp_q.size()) chk("block data", blk_data, exp_q[nblk]);
        else chk("block index", 512'(nblk), 512'(exp_q.size() - 1));
        chk("block last", 512'(blk_last), 512'(nblk == exp_q.size() - 1));
        lastb = blk_data;
        nblk++;
        tot_blk++;
        if (blk_last) done = 1'b1;
      end
      cyc++;
    end
    if (!done) chk("message timeout", 512'(done), 512'(1));
  endtask

  initial begin
    int           nblk;
    logic [511:0] lastb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    blk_ready = 1'b0;
    do_reset();

    // Reset state.
    chk("reset in_ready", 512'(in_ready), 512'(1));
    chk("reset blk_valid", 512'(blk_valid), 512'(0));
    chk("reset blk_last", 512'(blk_last), 512'(0));
    chk("reset blk_data", blk_data, 512'(0));
`ifdef SHA256_PADDER_BLKCNT_EN
    chk("reset blk_count", 512'(blk_count), 512'(0));
`endif

    tv[0] = '{0,  8'h00, 1'b0, 1, 32'h80000000, 32'h00000000};
    tv[1] = '{3,  8'h61, 1'b0, 1, 32'h61626380, 32'h00000018};
    tv[2] = '{56, 8'h00, 1'b0, 2, 32'h00000000, 32'h000001C0};
    tv[3] = '{64, 8'h00, 1'b0, 2, 32'h80000000, 32'h00000200};
    tv[4] = '{55, 8'h00, 1'b0, 1, 32'h00010203, 32'h000001B8};
    tv[5] = '{57, 8'h00, 1'b0, 2, 32'h00000000, 32'h000001C8};
    tv[6] = '{5,  8'h10, 1'b0, 1, 32'h10111213, 32'h00000028};
    tv[7] = '{64, 8'h00, 1'b1, 2, 32'h80000000, 32'h00000200};

    for (int t = 0; t < 8; t++) begin
      msg_q.delete();
      for (int k = 0; k < tv[t].nbytes; k++) msg_q.push_back(tv[t].base + 8'(k));
      run_msg(tv[t].split, 1'b0, nblk, lastb);
      chk("vec block count", 512'(nblk), 512'(tv[t].nblk));
      chk("vec final W0", 512'(lastb[511:480]), 512'(tv[t].w0));
      chk("vec final W15", 512'(lastb[31:0]), 512'(tv[t].w15));
    end

    // Stall: block held while blk_ready is low, one-cycle latency, trailing bytes ignored.
    idle();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    build_model();
    in_valid  = 1'b1;
    in_data   = 32'h616263A5;
    in_last   = 1'b1;
    in_bytes  = 3'd3;
    blk_ready = 1'b0;
    chk("stall in_ready before", 512'(in_ready), 512'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency blk_valid", 512'(blk_valid), 512'(1));
    for (int c = 0; c < 5; c++) begin
      chk("stall data", blk_data, exp_q[0]);
      chk("stall last", 512'(blk_last), 512'(1));
      chk("stall in_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
    end
    blk_ready = 1'b1;
    chk("stall valid at release", 512'(blk_valid), 512'(1));
    tot_blk++;
    @(negedge clk);
    blk_ready = 1'b0;
    chk("post xfer in_ready", 512'(in_ready), 512'(1));
    chk("post xfer blk_valid", 512'(blk_valid), 512'(0));

    // Reset after 7 words, with a word offered on the reset cycle.
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    tot_blk  = 0;
    chk("partial reset in_ready", 512'(in_ready), 512'(1));
    chk("partial reset blk_valid", 512'(blk_valid), 512'(0));
    chk("partial reset blk_data", blk_data, 512'(0));
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg(1'b0, 1'b0, nblk, lastb);
    chk("abc after reset count", 512'(nblk), 512'(1));

    // Reset while a block is pending, with blk_ready asserted on the same cycle.
    idle();
    in_valid = 1'b1;
    in_data  = 32'h61626300;
    in_last  = 1'b1;
    in_bytes = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    blk_ready = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    blk_ready = 1'b0;
    tot_blk   = 0;
    chk("pending reset blk_valid", 512'(blk_valid), 512'(0));
    chk("pending reset blk_last", 512'(blk_last), 512'(0));
    chk("pending reset in_ready", 512'(in_ready), 512'(1));

    // Random messages, back to back, random handshakes.
    for (int m = 0; m < 30; m++) begin
      int len;
      len = $urandom_range(140);
      msg_q.delete();
      for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
      run_msg(1'($urandom_range(1)), 1'b1, nblk, lastb);
      chk("random block count", 512'(nblk), 512'(exp_q.size()));
    end

`ifdef SHA256_PADDER_BLKCNT_EN
    idle();
    chk("blk_count total", 512'(blk_count), 512'(tot_blk));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
